// File: rtl/mic1_run_ctrl_if.sv
// Command channel between a debug host and the MIC-1 run controller.
// The host offers a command with cmd_valid; the controller accepts it
// when cmd_valid && cmd_ready.
interface mic1_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/mic1_run_ctrl.sv
// MIC-1 run controller: free-run, single/multi-step, breakpoint and halt
// handling, plus a saturating count of executed microinstruction cycles.
module mic1_run_ctrl #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mic1_run_ctrl_if.slave   cmd,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             halt_req,
  output logic             run,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic             cmd_err,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t             state_q, state_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               bp_hit_q, bp_hit_d;
  logic               cmd_err_q, cmd_err_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

  logic accept;
  logic active;
  logic bp_match;
  logic stop_now;

  // Commands are taken every cycle outside reset; nothing is ever queued.
  assign cmd.cmd_ready = !reset;
  assign accept        = cmd.cmd_valid && !reset;

  // The first cycle after entering RUN/STEP ignores the breakpoint so that
  // resuming from the breakpoint PC actually executes that instruction.
  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign bp_match = bp_en && (pc == bp_addr) && !first_q;
  assign stop_now = halt_req || bp_match;
  assign run      = active && !stop_now;

  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign cmd_err     = cmd_err_q;
  assign cycle_count = cycle_count_q;

  // Next-state logic: exits ordered halt > breakpoint > STOP > step exhaustion.
  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    remaining_d   = remaining_q;
    bp_hit_d      = bp_hit_q;
    cmd_err_d     = 1'b0;
    cycle_count_d = cycle_count_q;

    if (run && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
    if ((state_q == ST_STEP) && run && (remaining_q != '0)) begin
      remaining_d = remaining_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              first_d = 1'b1;
            end
            OP_STEP: begin
              if (cmd.cmd_count != '0) begin
                state_d     = ST_STEP;
                first_d     = 1'b1;
                remaining_d = cmd.cmd_count;
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              cycle_count_d = '0;
              bp_hit_d      = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        if (accept && (cmd.cmd_op != OP_STOP)) begin
          cmd_err_d = 1'b1;
        end
        if (halt_req) begin
          state_d = ST_HALTED;
        end else if (bp_match) begin
          state_d  = ST_IDLE;
          bp_hit_d = 1'b1;
        end else if (accept && (cmd.cmd_op == OP_STOP)) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_STEP) && run && (remaining_q == CNT_W'(1))) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (accept) begin
          if (cmd.cmd_op == OP_CLEAR) begin
            state_d       = ST_IDLE;
            cycle_count_d = '0;
            bp_hit_d      = 1'b0;
          end else if (cmd.cmd_op != OP_STOP) begin
            cmd_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      first_q       <= 1'b0;
      remaining_q   <= '0;
      bp_hit_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      remaining_q   <= remaining_d;
      bp_hit_q      <= bp_hit_d;
      cmd_err_q     <= cmd_err_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Scoreboard bench for mic1_run_ctrl: directed scenarios followed by random
// stimulus, compared against a behavioural model of the run controller.
// A second instance with a 4-bit cycle counter shares the same stimulus.
module tb_mic1_run_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;
  localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLEAR = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        halt_req;
  logic        run, bp_hit, cmd_err;
  logic [1:0]  state;
  logic [31:0] cycle_count;
  logic        run4, bp_hit4, cmd_err4;
  logic [1:0]  state4;
  logic [3:0]  cycle_count4;

  mic1_run_ctrl_if #(.CNT_W(16)) cif ();
  mic1_run_ctrl_if #(.CNT_W(16)) cif4 ();

  assign cif4.cmd_valid = cif.cmd_valid;
  assign cif4.cmd_op    = cif.cmd_op;
  assign cif4.cmd_count = cif.cmd_count;

  always #5 clk = ~clk;

  mic1_run_ctrl #(.CNT_W(16), .CYC_W(32)) dut (
    .clk(clk), .reset(reset), .cmd(cif.slave), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .halt_req(halt_req), .run(run), .state(state), .bp_hit(bp_hit),
    .cmd_err(cmd_err), .cycle_count(cycle_count)
  );

  mic1_run_ctrl #(.CNT_W(16), .CYC_W(4)) dut4 (
    .clk(clk), .reset(reset), .cmd(cif4.slave), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .halt_req(halt_req), .run(run4), .state(state4), .bp_hit(bp_hit4),
    .cmd_err(cmd_err4), .cycle_count(cycle_count4)
  );

  typedef struct {
    bit          chk_reg;
    bit          chk_run;
    logic        ready;
    logic        run;
    logic [1:0]  st;
    logic        bp;
    logic        err;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: plain integers describing what the controller should be doing.
  int m_st    = S_IDLE;
  bit m_first = 0;
  int m_rem   = 0;
  bit m_bp    = 0;
  bit m_err   = 0;
  int m_cnt   = 0;
  bit m_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("cmd_ready", {31'd0, cif.cmd_ready}, {31'd0, e.ready});
      if (e.chk_run) chk("run", {31'd0, run}, {31'd0, e.run});
      if (e.chk_reg) begin
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("bp_hit", {31'd0, bp_hit}, {31'd0, e.bp});
        chk("cmd_err", {31'd0, cmd_err}, {31'd0, e.err});
        chk("cycle_count", cycle_count, e.cnt);
        chk("cycle_count_sat4", {28'd0, cycle_count4}, {28'd0, e.cnt4});
      end
    end
  end

  // Drive one cycle of inputs, record what the DUT should show, advance the model.
  task automatic cyc(input bit rst, input bit v, input logic [1:0] op, input int cnt,
                     input bit be, input logic [31:0] ba, input logic [31:0] p, input bit h);
    exp_t e;
    bit   active, match, stop, running, acc, rej;
    reset         = rst;
    cif.cmd_valid = v;
    cif.cmd_op    = op;
    cif.cmd_count = 16'(cnt);
    bp_en         = be;
    bp_addr       = ba;
    pc            = p;
    halt_req      = h;
    if (!rst && v) $display("cmd t=%0t op=%0d count=%0d state=%0d", $time, op, cnt, m_st);

    active  = (m_st == S_RUN) || (m_st == S_STEP);
    match   = be && (p == ba) && !m_first;
    stop    = h || match;
    running = active && !stop;

    e.chk_reg = m_known;
    e.chk_run = m_known && !rst;
    e.ready   = !rst;
    e.run     = running;
    e.st      = 2'(m_st);
    e.bp      = m_bp;
    e.err     = m_err;
    e.cnt     = 32'(m_cnt);
    e.cnt4    = 4'((m_cnt > 15) ? 15 : m_cnt);
    sbq.push_back(e);

    if (rst) begin
      m_known = 1; m_st = S_IDLE; m_first = 0; m_rem = 0; m_bp = 0; m_err = 0; m_cnt = 0;
    end else begin
      acc     = v;
      rej     = 0;
      m_first = 0;
      if (running) m_cnt++;
      if (m_st == S_IDLE) begin
        if (acc && op == OP_RUN) begin m_st = S_RUN; m_first = 1; end
        else if (acc && op == OP_STEP && cnt == 0) rej = 1;
        else if (acc && op == OP_STEP) begin m_st = S_STEP; m_rem = cnt; m_first = 1; end
        else if (acc && op == OP_CLEAR) begin m_cnt = 0; m_bp = 0; end
      end else if (m_st == S_HALT) begin
        if (acc && op == OP_CLEAR) begin m_st = S_IDLE; m_cnt = 0; m_bp = 0; end
        else if (acc && op != OP_STOP) rej = 1;
      end else begin
        if (acc && op != OP_STOP) rej = 1;
        if (running && m_st == S_STEP) m_rem--;
        if (h) m_st = S_HALT;
        else if (match) begin m_st = S_IDLE; m_bp = 1; end
        else if (acc && op == OP_STOP) m_st = S_IDLE;
        else if (m_st == S_STEP && m_rem == 0) m_st = S_IDLE;
      end
      m_err = rej;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, OP_STOP, 0, 0, 32'd0, 32'd0, 0);
  endtask

  task automatic send(input logic [1:0] op, input int cnt);
    cyc(0, 1, op, cnt, 0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    reset = 1'b1; cif.cmd_valid = 1'b0; cif.cmd_op = OP_STOP; cif.cmd_count = '0;
    bp_en = 1'b0; bp_addr = '0; pc = '0; halt_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset from power-up.
    cyc(1, 0, OP_STOP, 0, 0, 0, 0, 0);
    cyc(1, 1, OP_RUN, 0, 0, 0, 0, 0);
    idle(2);

    // STEP 3 from IDLE.
    send(OP_STEP, 3);
    idle(5);

    // STEP 0 rejected; RUN while running rejected; STOP ends the run.
    send(OP_STEP, 0);
    idle(2);
    send(OP_RUN, 0);
    idle(3);
    send(OP_RUN, 0);
    idle(2);
    send(OP_STOP, 0);
    idle(2);

    // Breakpoint at 0x10 reached on the fifth run cycle, then resume from it.
    cyc(0, 1, OP_RUN, 0, 1, 32'h10, 32'h0, 0);
    for (int k = 1; k <= 6; k++) cyc(0, 0, OP_STOP, 0, 1, 32'h10, 32'((k - 1) * 4), 0);
    cyc(0, 1, OP_RUN, 0, 1, 32'h10, 32'h10, 0);
    cyc(0, 0, OP_STOP, 0, 1, 32'h10, 32'h10, 0);
    cyc(0, 0, OP_STOP, 0, 1, 32'h10, 32'h14, 0);
    cyc(0, 0, OP_STOP, 0, 1, 32'h10, 32'h18, 0);
    cyc(0, 1, OP_STOP, 0, 1, 32'h10, 32'h1C, 0);
    idle(2);
    send(OP_CLEAR, 0);
    idle(2);

    // Halt, breakpoint and STOP together; RUN in HALTED; CLEAR recovers.
    send(OP_RUN, 0);
    idle(2);
    cyc(0, 1, OP_STOP, 0, 1, 32'h40, 32'h40, 1);
    idle(2);
    send(OP_RUN, 0);
    idle(2);
    send(OP_CLEAR, 0);
    idle(2);

    // Twenty running cycles saturate the 4-bit counter.
    send(OP_RUN, 0);
    idle(20);
    send(OP_STOP, 0);
    idle(2);

    // Reset in the middle of an 8-step burst.
    send(OP_STEP, 8);
    idle(3);
    cyc(1, 0, OP_STOP, 0, 0, 0, 0, 0);
    cyc(1, 1, OP_STEP, 4, 0, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          r, v, be, h;
      logic [1:0]  op;
      int          cnt;
      logic [31:0] ba, p;
      r   = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) == 0);
      op  = 2'($urandom_range(0, 3));
      cnt = $urandom_range(0, 4);
      be  = $urandom_range(0, 1) == 1;
      ba  = 32'($urandom_range(0, 7));
      p   = 32'($urandom_range(0, 7));
      h   = ($urandom_range(0, 31) == 0);
      cyc(r, v, op, cnt, be, ba, p, h);
    end
    idle(1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
